// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared block geometry and loader FSM states for the ME current-block path
package me_pkg;

  localparam int BLK_SIZE = 16;
  localparam int PIX_W    = 8;
  localparam int WPR      = BLK_SIZE / 4;
  localparam int WPB      = BLK_SIZE * BLK_SIZE / 4;
  localparam int ROW_W    = BLK_SIZE * PIX_W;
  localparam int AW       = $clog2(WPB);
  localparam int RW       = $clog2(BLK_SIZE);
  localparam int CW       = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Row that word k of a block lands in.
  function automatic logic [RW-1:0] word_row(input logic [AW-1:0] k);
    return RW'(k / AW'(WPR));
  endfunction

  // 32-bit slot within the row that word k of a block lands in.
  function automatic logic [CW-1:0] word_col(input logic [AW-1:0] k);
    return CW'(k % AW'(WPR));
  endfunction

endpackage

// File: rtl/cur_blk_bank.sv
// rtl/cur_blk_bank.sv - one BLK_SIZE x BLK_SIZE pixel bank, word write port, row read port
module cur_blk_bank
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [31:0]      wdata,
  input  logic [RW-1:0]    raddr,
  output logic [ROW_W-1:0] rdata
);

  logic [ROW_W-1:0] mem [BLK_SIZE];

  // Each memory word fills four adjacent pixels of one row; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[word_row(waddr)][32*word_col(waddr) +: 32] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cur_blk_loader.sv
// rtl/cur_blk_loader.sv - ping-pong current-block loader feeding the ME array one row per beat
module cur_blk_loader
  import me_pkg::*;
#(
  parameter  int NUM_BLK = 8160,
  localparam int BW      = $clog2(NUM_BLK + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      read_en,
  input  logic [31:0]               cur_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BLK_SIZE*PIX_W-1:0] out_row,
  output logic                      out_last,
  output logic [BW-1:0]             out_blk_idx,
  output logic                      frame_done
);

  state_t           state;
  logic [1:0]       full;
  logic             wr_bank;
  logic             rd_bank;
  logic [AW-1:0]    word_cnt;
  logic [RW-1:0]    rd_row;
  logic [BW-1:0]    blk_loaded;
  logic [BW-1:0]    blk_sent;
  logic [ROW_W-1:0] row0;
  logic [ROW_W-1:0] row1;
  logic             load_done;
  logic             drain;
  logic             drain_done;

  // Loading stalls only on a full target bank; data never gates the strobe.
  assign read_en    = (state == RUN) && !full[wr_bank];
  assign load_done  = read_en && (word_cnt == AW'(WPB - 1));

  assign out_valid  = full[rd_bank];
  assign drain      = out_valid && out_ready;
  assign out_last   = out_valid && (rd_row == RW'(BLK_SIZE - 1));
  assign drain_done = drain && out_last;
  assign out_blk_idx = blk_sent;
  // Gate with valid so an empty buffer presents zeros rather than stale pixels.
  assign out_row    = out_valid ? (rd_bank ? row1 : row0) : '0;

  cur_blk_bank u_bank0 (
    .clk   (clk),
    .we    (read_en && !wr_bank),
    .waddr (word_cnt),
    .wdata (cur_data),
    .raddr (rd_row),
    .rdata (row0)
  );

  cur_blk_bank u_bank1 (
    .clk   (clk),
    .we    (read_en && wr_bank),
    .waddr (word_cnt),
    .wdata (cur_data),
    .raddr (rd_row),
    .rdata (row1)
  );

  // Frame FSM plus load/drain bookkeeping; set and clear of full[] always target different banks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      word_cnt   <= '0;
      rd_row     <= '0;
      blk_loaded <= '0;
      blk_sent   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_done) begin
        busy <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start && !busy) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // Leave RUN on the final word itself so no read is issued past the frame.
          if (load_done && (blk_loaded == BW'(NUM_BLK - 1))) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (drain_done && (blk_sent == BW'(NUM_BLK - 1))) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (read_en) begin
        if (load_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          word_cnt      <= '0;
          blk_loaded    <= (blk_loaded == BW'(NUM_BLK - 1)) ? '0 : blk_loaded + 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end

      if (drain) begin
        if (out_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_row        <= '0;
          blk_sent      <= (blk_sent == BW'(NUM_BLK - 1)) ? '0 : blk_sent + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cur_blk_loader.sv
// tb/tb_cur_blk_loader.sv - self-checking bench for cur_blk_loader
module tb_cur_blk_loader;

  localparam int NB   = 4;
  localparam int BS   = 16;
  localparam int BWT  = $clog2(NB + 1);
  localparam int MAXR = 2048;

  logic           clk;
  logic           rst;
  logic           start;
  logic           busy;
  logic           read_en;
  logic [31:0]    cur_data;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_row;
  logic           out_last;
  logic [BWT-1:0] out_blk_idx;
  logic           frame_done;

  int n_checks = 0;
  int n_err    = 0;
  int pat      = 0;
  int mem_addr;
  int n_reads  = 0;
  int n_rows   = 0;
  int n_fd     = 0;

  logic [127:0]   acc_row  [MAXR];
  logic           acc_last [MAXR];
  logic [BWT-1:0] acc_idx  [MAXR];

  typedef struct {
    int ready_pct;
    int pat;
    bit spam;
    int exp_reads;
    int exp_rows;
    int exp_fd;
  } vec_t;

  vec_t tbl [4];

  cur_blk_loader #(.NUM_BLK(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .read_en     (read_en),
    .cur_data    (cur_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_last    (out_last),
    .out_blk_idx (out_blk_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input int a, input int p);
    int t;
    if (p == 0) t = a;
    else        t = a * 131 + (a >>> 8) * 17 + 5;
    return t[7:0];
  endfunction

  // Row g of the frame stream covers byte addresses 16g .. 16g+15.
  function automatic logic [127:0] exp_row(input int g, input int p);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < BS; c++) r[8*c +: 8] = mem_byte(16 * g + c, p);
    return r;
  endfunction

  // Current-frame memory: sequential word reads, address cleared by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) mem_addr <= 0;
    else if (read_en) mem_addr <= mem_addr + 1;
  end

  always_comb begin
    cur_data = '0;
    for (int b = 0; b < 4; b++) cur_data[8*b +: 8] = mem_byte(4 * mem_addr + b, pat);
  end

  // Monitor: counts reads and frame_done pulses, records every accepted row.
  always @(negedge clk) begin
    if (rst) begin
      if (read_en) n_reads <= n_reads + 1;
      if (frame_done) n_fd <= n_fd + 1;
      if (out_valid && out_ready) begin
        if (n_rows < MAXR) begin
          acc_row[n_rows]  <= out_row;
          acc_last[n_rows] <= out_last;
          acc_idx[n_rows]  <= out_blk_idx;
        end
        n_rows <= n_rows + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 0; start = 0; out_ready = 0;
    repeat (2) cyc();
    rst = 1;
    cyc();
  endtask

  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_read_en"},    read_en, 0);
    chk({tag, "_out_valid"},  out_valid, 0);
    chk({tag, "_out_last"},   out_last, 0);
    chk({tag, "_blk_idx"},    out_blk_idx, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_out_row"},    out_row, 0);
  endtask

  task automatic verify_rows(input int base, input int cnt, input int p);
    for (int i = 0; i < cnt && base + i < MAXR; i++) begin
      chk("row_data", acc_row[base + i], exp_row(i, p));
      chk("row_last", acc_last[base + i], (i % BS) == BS - 1);
      chk("row_idx",  acc_idx[base + i], i / BS);
    end
  endtask

  initial begin
    int r0, w0, f0, bound;
    bit got, prev;

    tbl[0] = '{ready_pct: 100, pat: 1, spam: 0, exp_reads: 256, exp_rows: 64, exp_fd: 1};
    tbl[1] = '{ready_pct: 50,  pat: 1, spam: 0, exp_reads: 256, exp_rows: 64, exp_fd: 1};
    tbl[2] = '{ready_pct: 30,  pat: 1, spam: 1, exp_reads: 256, exp_rows: 64, exp_fd: 1};
    tbl[3] = '{ready_pct: 80,  pat: 0, spam: 1, exp_reads: 256, exp_rows: 64, exp_fd: 1};

    clk = 0; rst = 0; start = 0; out_ready = 0; pat = 0;
    repeat (3) cyc();
    chk_all_zero("reset");
    rst = 1;
    repeat (2) cyc();

    // First-block latency: reads in cycles 1..64, valid in cycle 65.
    pulse_start();
    for (int i = 1; i <= 64; i++) begin
      chk("lat_read_en", read_en, 1);
      chk("lat_valid_early", out_valid, 0);
      cyc();
    end
    chk("lat_valid", out_valid, 1);
    chk("lat_row0", out_row, exp_row(0, 0));
    chk("lat_idx0", out_blk_idx, 0);
    chk("lat_busy", busy, 1);

    // Back-pressure: both banks fill, reads stop at 128.
    bound = 0;
    while (read_en && bound < 400) begin cyc(); bound++; end
    chk("bp_reads", n_reads, 128);
    for (int i = 0; i < 10; i++) begin
      chk("bp_read_en_held", read_en, 0);
      cyc();
    end
    chk("bp_row_frozen", out_row, exp_row(0, 0));
    out_ready = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("bp_read_en_before", read_en, 0);
      cyc();
    end
    out_ready = 0;
    chk("bp_read_en_resume", read_en, 1);
    chk("bp_idx1", out_blk_idx, 1);

    // Drain the rest with ready held high.
    out_ready = 1;
    got = 0; prev = 0; bound = 0;
    while (!got && bound < 3000) begin
      if (frame_done) got = 1;
      else begin
        prev = out_valid && out_ready && out_last && (out_blk_idx == BWT'(NB - 1));
        cyc();
        bound++;
      end
    end
    chk("f1_done_seen", got, 1);
    chk("f1_done_after_last", prev, 1);
    chk("f1_rows", n_rows, 64);
    verify_rows(0, 64, 0);
    cyc();
    chk("f1_busy_low", busy, 0);
    chk("f1_done_single", frame_done, 0);
    chk("f1_reads", n_reads, 256);
    chk("f1_fd", n_fd, 1);

    // Randomized frames against the reference stream.
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      pat = tbl[t].pat;
      r0 = n_reads; w0 = n_rows; f0 = n_fd;
      pulse_start();
      got = 0; bound = 0;
      while (!got && bound < 6000) begin
        if (frame_done) got = 1;
        else begin
          out_ready = ($urandom_range(0, 99) < tbl[t].ready_pct);
          start = tbl[t].spam && busy && ($urandom_range(0, 15) == 0);
          cyc();
          bound++;
        end
      end
      start = 0;
      out_ready = 1;
      repeat (20) cyc();
      chk("rnd_done_seen", got, 1);
      chk("rnd_reads", n_reads - r0, tbl[t].exp_reads);
      chk("rnd_rows", n_rows - w0, tbl[t].exp_rows);
      chk("rnd_fd", n_fd - f0, tbl[t].exp_fd);
      chk("rnd_busy_low", busy, 0);
      verify_rows(w0, tbl[t].exp_rows, tbl[t].pat);
    end

    // Reset mid-frame at read 30 of block 1, then a clean frame.
    apply_reset();
    pat = 0;
    out_ready = 1;
    r0 = n_reads;
    pulse_start();
    bound = 0;
    while (n_reads - r0 < 94 && bound < 1000) begin cyc(); bound++; end
    chk("mid_reads_reached", n_reads - r0, 94);
    f0 = n_fd;
    rst = 0;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) cyc();
    chk_all_zero("mid_reset_held");
    rst = 1;
    cyc();
    pat = 1;
    r0 = n_reads; w0 = n_rows;
    pulse_start();
    got = 0; bound = 0;
    while (!got && bound < 3000) begin
      if (frame_done) got = 1;
      else begin cyc(); bound++; end
    end
    repeat (5) cyc();
    chk("mid_done_seen", got, 1);
    chk("mid_reads", n_reads - r0, 256);
    chk("mid_rows", n_rows - w0, 64);
    chk("mid_fd", n_fd - f0, 1);
    verify_rows(w0, 64, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cur_blk_loader.md
Name: cur_blk_loader

Overview:
- Sits directly downstream of the current-frame memory.
- Pulls the 32-bit current-frame word stream by driving that memory's read_en.
- Assembles BLK_SIZE x BLK_SIZE current blocks into a two-bank ping-pong buffer.
- Presents each block one full row per beat to the ME search array over a valid/ready handshake, so the next block loads while the current one drains.

Parameters:
- BLK_SIZE, 16, block edge in pixels; multiple of 4.
- PIX_W, 8, bits per pixel; the memory word carries 4 pixels, so PIX_W is fixed at 8.
- NUM_BLK, 8160, blocks per frame (1920x1088 / 256).
- Derived, WPB = BLK_SIZE*BLK_SIZE/4 (64 words per block); BW = $clog2(NUM_BLK+1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle frame_done pulses.
- read_en  out  1  read strobe to the current-frame memory.
- cur_data  in  32  memory word, valid in the same cycle read_en=1; byte0 = leftmost pixel.
- out_valid  out  1  a row is available.
- out_ready  in  1  the consumer accepts the row.
- out_row  out  BLK_SIZE*PIX_W  one block row; column c at bits [PIX_W*c +: PIX_W].
- out_last  out  1  out_row is the final row of its block.
- out_blk_idx  out  BW  index of the block being presented, 0..NUM_BLK-1.
- frame_done  out  1  one-cycle pulse after the last row of block NUM_BLK-1 is accepted.

Behaviour:
- Reset (rst=0, async): every output is 0; FSM goes to IDLE; both bank-full flags, bank pointers, word/row/block counters are 0. Bank contents are don't-care.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> FLUSH when blk_loaded == NUM_BLK.
  - FLUSH -> IDLE when blk_sent == NUM_BLK; frame_done pulses in that same transition cycle.
- Input stream order: block-major, row-major inside a block.
  - Word k of a block maps to row k/(BLK_SIZE/4), columns 4*(k%(BLK_SIZE/4))..+3.
- Load side:
  - read_en = (state==RUN) && !full[wr_bank]. Combinational from registered state only; cur_data is never a term.
  - On each clk edge with read_en=1, cur_data is written into bank wr_bank at word_cnt, then word_cnt++.
  - When word_cnt == WPB-1 on a read: set full[wr_bank], toggle wr_bank, clear word_cnt, blk_loaded++.
  - read_en falls in the cycle after the 64th read of block NUM_BLK-1; no extra reads are issued.
- Drain side:
  - out_valid = full[rd_bank].
  - out_row = row rd_row of bank rd_bank, read combinationally; stable while out_valid && !out_ready.
  - out_last = out_valid && rd_row == BLK_SIZE-1.
  - out_blk_idx = blk_sent.
  - On out_valid && out_ready: rd_row++. On the last row: clear full[rd_bank], toggle rd_bank, rd_row=0, blk_sent++.
- Latency:
  - First read_en is in the cycle after start.
  - out_valid for block 0 rises in the cycle after its 64th read.
  - With out_ready held at 1, throughput is bounded by load: 64 cycles per block vs 16 to drain.
- Simultaneous events: set and clear of full[] in the same cycle always hit different banks (a write needs an empty bank, a read needs a full bank). Both apply.
- Back-pressure: with both banks full, read_en=0 until a bank drains. The cycle after the clear, read_en=1 again.
- Reset mid-frame: aborts immediately; partially loaded data is discarded. The top level must also reset the memory's address counter; this block never rewinds it.

Decomposition:
- Package me_pkg holds BLK_SIZE, PIX_W, WPB, and the FSM state enum (IDLE, RUN, FLUSH).
- One sub-module: cur_blk_bank.
  - A BLK_SIZE-row x BLK_SIZE*PIX_W register file.
  - 32-bit write port addressed by word index; combinational row read port.
  - Instantiated twice.

Test Plan:
- Reset then start with memory bytes = address mod 256 -> read_en high for cycles 1..64. Block 0 row 0 = bytes 0x00..0x0F, column 0 in LSB. out_valid rises in cycle 65.
- out_ready tied 1, NUM_BLK=4 -> exactly 256 read_en cycles; 64 rows out; out_last on rows 15/31/47/63; out_blk_idx 0..3; frame_done pulses once, 1 cycle after row 63 is accepted; busy then falls.
- out_ready held 0 -> read_en stops after 128 reads (both banks full). out_row stays frozen on block 0 row 0. Raising out_ready for 16 cycles resumes read_en exactly 1 cycle after the 16th accept.
- Random out_ready toggling, NUM_BLK=4 -> scoreboard matches all 1024 bytes in order; no row is dropped or duplicated.
- Deassert rst at read 30 of block 1 -> all outputs 0 asynchronously; after release, a new start produces block 0 from memory address 0.
- start pulsed while busy -> no effect: the read count and frame_done count stay unchanged.
